// File: rtl/usb_auth_xfer_ctrl.sv
// ============================================================================
// Module  : usb_auth_xfer_ctrl
// Brief   : Type-C attach debounce plus one auth request/response exchange
//           with the USB host, including per-attempt timeout and retries.
//           Optional response header check: define AUTH_HDR_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_auth_xfer_ctrl #(
   parameter int MSG_W     = 2080,
   parameter int DEBOUNCE  = 4,
   parameter int TIMEOUT   = 16,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             CC1,
   input  logic             CC2,
   input  logic             core_req,
   input  logic [MSG_W-1:0] core_msg,
   output logic             core_ready,
   output logic             core_done,
   output logic             core_err,
   output logic [1:0]       err_code,
   output logic [MSG_W-1:0] core_resp,
   output logic             attached,
   output logic             orient,
   output logic             resp_req_out,
   output logic [MSG_W-1:0] auth_msg_resp_out,
   input  logic             Ack_out_resp,
   input  logic             resp_req_in,
   input  logic [MSG_W-1:0] auth_msg_resp_in
);

   localparam int c_DEB_W = $clog2(DEBOUNCE + 1);
   localparam int c_TMR_W = $clog2(TIMEOUT) + 1;
   localparam int c_RTY_W = $clog2(MAX_RETRY + 1) + 1;

   localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEBOUNCE);
   localparam logic [c_TMR_W-1:0] c_TMR_EXP = c_TMR_W'(TIMEOUT - 1);
   localparam logic [c_RTY_W-1:0] c_RTY_MAX = c_RTY_W'(MAX_RETRY);

   localparam logic [1:0] c_ERR_NONE    = 2'b00;
   localparam logic [1:0] c_ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] c_ERR_HDR     = 2'b10;
   localparam logic [1:0] c_ERR_DETACH  = 2'b11;

   typedef enum logic [2:0] {
      S_DETACHED  = 3'd0,
      S_IDLE      = 3'd1,
      S_SEND      = 3'd2,
      S_WAIT_RESP = 3'd3,
      S_DONE      = 3'd4,
      S_ERROR     = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [c_DEB_W-1:0]   r_deb_cnt;
   logic [c_DEB_W-1:0]   w_deb_next;
   logic                 r_last_orient;
   logic                 r_attached;
   logic                 r_orient;
   logic [c_TMR_W-1:0]   r_timer;
   logic [c_RTY_W-1:0]   r_retry;
   logic [1:0]           r_err_code;
   logic [MSG_W-1:0]     r_msg_out;
   logic [MSG_W-1:0]     r_resp;
   logic                 r_det_err;

   logic                 w_cc_valid;
   logic                 w_attach_set;
   logic                 w_expired;
   logic                 w_retry_ok;
   logic                 w_hdr_ok;
   logic                 w_accept;
   logic                 w_timer_clr;
   logic                 w_retry_inc;
   logic                 w_capture;
   logic                 w_set_code;
   logic [1:0]           w_code_val;
   logic                 w_det_err;

   assign w_cc_valid = CC1 ^ CC2;
   assign w_expired  = (r_timer >= c_TMR_EXP);
   assign w_retry_ok = (r_retry < c_RTY_MAX);

   // A run restarts on any invalid cycle or orientation change.
   always_comb begin
      w_deb_next = '0;
      if (w_cc_valid && ((r_deb_cnt == '0) || (CC2 == r_last_orient))) begin
         w_deb_next = (r_deb_cnt == c_DEB_MAX) ? r_deb_cnt : r_deb_cnt + 1'b1;
      end
   end

   assign w_attach_set = !r_attached && w_cc_valid && (w_deb_next == c_DEB_MAX);

`ifdef AUTH_HDR_CHK_EN
   assign w_hdr_ok = (auth_msg_resp_in[MSG_W-1 -: 8] == r_msg_out[MSG_W-1 -: 8]) &&
                     (auth_msg_resp_in[MSG_W-9 -: 8] == (r_msg_out[MSG_W-9 -: 8] ^ 8'h80));
`else
   assign w_hdr_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_deb_cnt     <= '0;
         r_last_orient <= 1'b0;
         r_attached    <= 1'b0;
         r_orient      <= 1'b0;
      end else begin
         r_deb_cnt     <= w_deb_next;
         r_last_orient <= CC2;
         if (!w_cc_valid) begin
            r_attached <= 1'b0;
         end else if (w_attach_set) begin
            r_attached <= 1'b1;
            r_orient   <= CC2;
         end
      end
   end

   // Detach overrides everything; ack/response beat the timeout.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_timer_clr  = 1'b0;
      w_retry_inc  = 1'b0;
      w_capture    = 1'b0;
      w_set_code   = 1'b0;
      w_code_val   = c_ERR_NONE;
      w_det_err    = 1'b0;
      if (!w_cc_valid) begin
         w_next_state = S_DETACHED;
         if ((r_state == S_SEND) || (r_state == S_WAIT_RESP)) begin
            w_det_err  = 1'b1;
            w_set_code = 1'b1;
            w_code_val = c_ERR_DETACH;
         end
      end else begin
         case (r_state)
            S_DETACHED: begin
               if (r_attached || w_attach_set) w_next_state = S_IDLE;
            end
            S_IDLE: begin
               if (core_req && r_attached) begin
                  w_accept     = 1'b1;
                  w_timer_clr  = 1'b1;
                  w_next_state = S_SEND;
               end
            end
            S_SEND: begin
               if (Ack_out_resp) begin
                  w_next_state = S_WAIT_RESP;
               end else if (w_expired) begin
                  if (w_retry_ok) begin
                     w_retry_inc  = 1'b1;
                     w_timer_clr  = 1'b1;
                     w_next_state = S_SEND;
                  end else begin
                     w_set_code   = 1'b1;
                     w_code_val   = c_ERR_TIMEOUT;
                     w_next_state = S_ERROR;
                  end
               end
            end
            S_WAIT_RESP: begin
               if (resp_req_in) begin
                  w_capture = 1'b1;
                  if (w_hdr_ok) begin
                     w_next_state = S_DONE;
                  end else begin
                     w_set_code   = 1'b1;
                     w_code_val   = c_ERR_HDR;
                     w_next_state = S_ERROR;
                  end
               end else if (w_expired) begin
                  if (w_retry_ok) begin
                     w_retry_inc  = 1'b1;
                     w_timer_clr  = 1'b1;
                     w_next_state = S_SEND;
                  end else begin
                     w_set_code   = 1'b1;
                     w_code_val   = c_ERR_TIMEOUT;
                     w_next_state = S_ERROR;
                  end
               end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERROR: w_next_state = S_IDLE;
            default: w_next_state = S_DETACHED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_DETACHED;
         r_timer    <= '0;
         r_retry    <= '0;
         r_err_code <= c_ERR_NONE;
         r_msg_out  <= '0;
         r_resp     <= '0;
         r_det_err  <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_det_err <= w_det_err;
         // Timer saturates so an exhausted budget stays exhausted in WAIT_RESP.
         if (w_timer_clr) begin
            r_timer <= '0;
         end else if (((r_state == S_SEND) || (r_state == S_WAIT_RESP)) &&
                      (r_timer != {c_TMR_W{1'b1}})) begin
            r_timer <= r_timer + 1'b1;
         end
         if (w_accept) begin
            r_retry    <= '0;
            r_err_code <= c_ERR_NONE;
            r_msg_out  <= core_msg;
         end else begin
            if (w_retry_inc) r_retry <= r_retry + 1'b1;
            if (w_set_code)  r_err_code <= w_code_val;
         end
         if (w_capture) r_resp <= auth_msg_resp_in;
      end
   end

   assign core_ready        = (r_state == S_IDLE) && r_attached;
   assign core_done         = (r_state == S_DONE);
   assign core_err          = (r_state == S_ERROR) || r_det_err;
   assign err_code          = r_err_code;
   assign core_resp         = r_resp;
   assign attached          = r_attached;
   assign orient            = r_orient;
   assign resp_req_out      = (r_state == S_SEND);
   assign auth_msg_resp_out = r_msg_out;

endmodule

`default_nettype wire
